// File: rtl/line_pkg.sv
// Shared definitions for the line_tx / line_rx serial pair.
package line_pkg;

   localparam logic [1:0] VERIFY_EVEN = 2'b00;
   localparam logic [1:0] VERIFY_ODD  = 2'b01;
   localparam logic [1:0] VERIFY_NONE = 2'b10;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } tx_state_t;

   // Mode 11 is reserved and behaves like "none".
   function automatic logic has_parity(input logic [1:0] mode);
      return !(mode == VERIFY_NONE || mode == 2'b11);
   endfunction

endpackage

// File: rtl/line_tx_if.sv
// Host-side bus of line_tx: byte write, mode/enable controls and status flags.
interface line_tx_if;
   logic [7:0] i_data;
   logic       i_wr_n;
   logic [1:0] i_verify_mode;
   logic       i_ce_n;
   logic       i_clear_int_n;
   logic       o_busy;
   logic       o_full;
   logic       o_tx_int;
   logic       o_ovr;

   modport master (
      output i_data, i_wr_n, i_verify_mode, i_ce_n, i_clear_int_n,
      input  o_busy, o_full, o_tx_int, o_ovr
   );

   modport slave (
      input  i_data, i_wr_n, i_verify_mode, i_ce_n, i_clear_int_n,
      output o_busy, o_full, o_tx_int, o_ovr
   );
endinterface

// File: rtl/line_tx_hold.sv
// One-deep holding register: write acceptance, full flag and sticky overrun.
module line_tx_hold (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_wr_n,
   input  logic [7:0] i_data,
   input  logic       i_drain,
   input  logic       i_clear_int_n,
   output logic       o_full,
   output logic       o_ovr,
   output logic [7:0] o_hr
);
   logic       r_full;
   logic       r_ovr;
   logic [7:0] r_hr;
   logic       w_accept;

   // A write landing on the draining cycle refills the register, so full stays set.
   assign w_accept = ~i_wr_n & (~r_full | i_drain);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_full <= 1'b0;
         r_ovr  <= 1'b0;
         r_hr   <= 8'h00;
      end else begin
         if (w_accept) begin
            r_hr   <= i_data;
            r_full <= 1'b1;
         end else if (i_drain) begin
            r_full <= 1'b0;
         end
         if (~i_wr_n & r_full & ~i_drain) r_ovr <= 1'b1;
         else if (!i_clear_int_n)         r_ovr <= 1'b0;
      end
   end

   assign o_full = r_full;
   assign o_ovr  = r_ovr;
   assign o_hr   = r_hr;
endmodule

// File: rtl/line_tx.sv
// Serial line transmitter: start, 8 data bits LSB first, optional parity, stop bit(s).
module line_tx
   import line_pkg::*;
#(
   parameter int STOP_BITS = 1
) (
   input  logic     i_clk,
   input  logic     i_rst_n,
   input  logic     i_clk_tx,
   line_tx_if.slave bus,
   output logic     o_tx_data
);
   tx_state_t  r_state;
   logic [7:0] r_shift;
   logic [2:0] r_cnt;
   logic [1:0] r_mode;
   logic       r_stop_cnt;
   logic       r_tx;
   logic       r_int;

   logic       w_qt;
   logic       w_last_stop;
   logic       w_drain;
   logic       w_full;
   logic       w_ovr;
   logic [7:0] w_hr;

   assign w_qt        = i_clk_tx & ~bus.i_ce_n;
   assign w_last_stop = (r_state == ST_STOP) && (r_stop_cnt == 1'(STOP_BITS - 1));
   assign w_drain     = w_qt & w_full & ((r_state == ST_IDLE) | w_last_stop);

   line_tx_hold u_hold (
      .i_clk         (i_clk),
      .i_rst_n       (i_rst_n),
      .i_wr_n        (bus.i_wr_n),
      .i_data        (bus.i_data),
      .i_drain       (w_drain),
      .i_clear_int_n (bus.i_clear_int_n),
      .o_full        (w_full),
      .o_ovr         (w_ovr),
      .o_hr          (w_hr)
   );

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state    <= ST_IDLE;
         r_shift    <= 8'h00;
         r_cnt      <= 3'd0;
         r_mode     <= VERIFY_NONE;
         r_stop_cnt <= 1'b0;
         r_tx       <= 1'b1;
         r_int      <= 1'b0;
      end else begin
         if (w_qt) begin
            case (r_state)
               ST_IDLE: begin
                  if (w_full) begin
                     r_shift <= w_hr;
                     r_mode  <= bus.i_verify_mode;
                     r_tx    <= 1'b0;
                     r_state <= ST_START;
                  end
               end
               ST_START: begin
                  r_tx    <= r_shift[0];
                  r_cnt   <= 3'd0;
                  r_state <= ST_DATA;
               end
               ST_DATA: begin
                  if (r_cnt != 3'd7) begin
                     r_cnt <= r_cnt + 3'd1;
                     r_tx  <= r_shift[r_cnt + 3'd1];
                  end else if (has_parity(r_mode)) begin
                     r_tx    <= (^r_shift) ^ (r_mode == VERIFY_ODD);
                     r_state <= ST_PARITY;
                  end else begin
                     r_tx       <= 1'b1;
                     r_stop_cnt <= 1'b0;
                     r_state    <= ST_STOP;
                  end
               end
               ST_PARITY: begin
                  r_tx       <= 1'b1;
                  r_stop_cnt <= 1'b0;
                  r_state    <= ST_STOP;
               end
               ST_STOP: begin
                  if (w_last_stop) begin
                     // Pending byte starts on this same tick: no idle gap.
                     if (w_full) begin
                        r_shift <= w_hr;
                        r_mode  <= bus.i_verify_mode;
                        r_tx    <= 1'b0;
                        r_state <= ST_START;
                     end else begin
                        r_tx    <= 1'b1;
                        r_state <= ST_IDLE;
                     end
                  end else begin
                     r_stop_cnt <= r_stop_cnt + 1'b1;
                  end
               end
               default: r_state <= ST_IDLE;
            endcase
         end
         if (w_qt && w_last_stop)     r_int <= 1'b1;
         else if (!bus.i_clear_int_n) r_int <= 1'b0;
      end
   end

   assign o_tx_data    = r_tx;
   assign bus.o_busy   = (r_state != ST_IDLE) | w_full;
   assign bus.o_full   = w_full;
   assign bus.o_tx_int = r_int;
   assign bus.o_ovr    = w_ovr;
endmodule

// File: tb/tb_line_tx.sv
// Randomised + directed bench for line_tx against a queue-based frame model.
module tb_line_tx;
   localparam int SB = 1;

   logic i_clk = 1'b0;
   logic i_rst_n = 1'b1;
   logic i_clk_tx = 1'b0;
   logic o_tx_data;
   line_tx_if bus();

   line_tx #(.STOP_BITS(SB)) dut (
      .i_clk    (i_clk),
      .i_rst_n  (i_rst_n),
      .i_clk_tx (i_clk_tx),
      .bus      (bus),
      .o_tx_data(o_tx_data)
   );

   always #5 i_clk = ~i_clk;

   int n_chk = 0;
   int n_err = 0;
   int tick_div = 16;
   bit chk_en = 0;

   // Tick generator: one-cycle pulse every tick_div cycles.
   initial begin
      int cnt;
      cnt = 0;
      forever begin
         @(posedge i_clk);
         #1;
         if (cnt >= tick_div - 1) cnt = 0; else cnt++;
         i_clk_tx = (cnt == 0);
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: each frame is a list of line levels, one popped per qualified tick;
   // the tick after the list runs dry ends the frame.
   bit         q[$];
   bit         m_active = 0, m_full = 0, m_int = 0, m_ovr = 0, m_line = 1;
   logic [7:0] m_hr = 8'h00;

   function automatic void push_frame(input logic [7:0] d, input logic [1:0] mode);
      int ones;
      ones = $countones(d);
      q.push_back(1'b0);
      for (int i = 0; i < 8; i++) q.push_back(d[i]);
      if (mode == 2'b00) q.push_back(bit'(ones % 2));
      if (mode == 2'b01) q.push_back(bit'(1 - ones % 2));
      for (int s = 0; s < SB; s++) q.push_back(1'b1);
   endfunction

   initial begin
      bit qt, drain, set_int, wr;
      forever begin
         @(posedge i_clk or negedge i_rst_n);
         if (!i_rst_n) begin
            q.delete();
            m_active = 0; m_full = 0; m_int = 0; m_ovr = 0; m_line = 1;
         end else begin
            qt = i_clk_tx & ~bus.i_ce_n;
            drain = 0; set_int = 0;
            if (qt) begin
               if (q.size() > 0) m_line = q.pop_front();
               else begin
                  if (m_active) begin set_int = 1; m_active = 0; end
                  if (m_full) begin
                     drain = 1;
                     push_frame(m_hr, bus.i_verify_mode);
                     m_active = 1;
                     m_line = q.pop_front();
                  end
               end
            end
            wr = ~bus.i_wr_n;
            if (wr && m_full && !drain) m_ovr = 1;
            else if (!bus.i_clear_int_n) m_ovr = 0;
            if (wr && (!m_full || drain)) begin m_hr = bus.i_data; m_full = 1; end
            else if (drain) m_full = 0;
            if (set_int) m_int = 1;
            else if (!bus.i_clear_int_n) m_int = 0;
         end
      end
   end

   always @(negedge i_clk) begin
      if (chk_en) begin
         chk("model line", 32'(o_tx_data), 32'(m_line));
         chk("model full", 32'(bus.o_full), 32'(m_full));
         chk("model busy", 32'(bus.o_busy), 32'(m_active | m_full));
         chk("model int", 32'(bus.o_tx_int), 32'(m_int));
         chk("model ovr", 32'(bus.o_ovr), 32'(m_ovr));
      end
   end

   logic [63:0] cb, ci;

   task automatic wait_qt(output bit ok);
      ok = 0;
      for (int t = 0; t < 3000; t++) begin
         @(negedge i_clk);
         if (i_clk_tx & ~bus.i_ce_n) begin ok = 1; break; end
      end
      if (!ok) chk("tick timeout", 32'd0, 32'd1);
   endtask

   // Record line and interrupt one cycle after each of n qualified ticks.
   task automatic cap(input int n, input int off);
      bit ok;
      for (int i = 0; i < n; i++) begin
         wait_qt(ok);
         if (!ok) return;
         @(negedge i_clk);
         cb[off + i] = o_tx_data;
         ci[off + i] = bus.o_tx_int;
      end
   endtask

   task automatic wr_byte(input logic [7:0] d, input logic [1:0] mode);
      @(posedge i_clk); #1;
      bus.i_data = d; bus.i_verify_mode = mode; bus.i_wr_n = 1'b0;
      @(posedge i_clk); #1;
      bus.i_wr_n = 1'b1;
   endtask

   task automatic clr();
      @(posedge i_clk); #1; bus.i_clear_int_n = 1'b0;
      @(posedge i_clk); #1; bus.i_clear_int_n = 1'b1;
   endtask

   int e_a5[10]  = '{0,1,0,1,0,0,1,0,1,1};
   int e_01e[11] = '{0,1,0,0,0,0,0,0,0,1,1};
   int e_01o[11] = '{0,1,0,0,0,0,0,0,0,0,1};
   int e_3c[20]  = '{0,0,0,1,1,1,1,0,0,1, 0,1,1,0,0,0,0,1,1,1};
   int e_08[10]  = '{0,0,0,0,1,0,0,0,0,1};
   int e_5a[10]  = '{0,0,1,0,1,1,0,1,0,1};

   initial begin
      bit ok;
      bus.i_data = 8'h00; bus.i_wr_n = 1'b1; bus.i_verify_mode = 2'b10;
      bus.i_ce_n = 1'b0; bus.i_clear_int_n = 1'b1;
      #1 i_rst_n = 1'b0;
      #1 chk_en = 1;
      repeat (3) @(negedge i_clk);
      chk("reset line", 32'(o_tx_data), 32'd1);
      chk("reset busy", 32'(bus.o_busy), 32'd0);
      chk("reset full", 32'(bus.o_full), 32'd0);
      chk("reset int", 32'(bus.o_tx_int), 32'd0);
      chk("reset ovr", 32'(bus.o_ovr), 32'd0);
      @(posedge i_clk); #1 i_rst_n = 1'b1;
      repeat (20) @(posedge i_clk);

      // 0xA5, no parity
      wr_byte(8'hA5, 2'b10);
      cap(11, 0);
      for (int i = 0; i < 10; i++) chk($sformatf("a5 bit%0d", i), 32'(cb[i]), 32'(e_a5[i]));
      chk("a5 int early", 32'(ci[9]), 32'd0);
      chk("a5 int", 32'(ci[10]), 32'd1);
      clr();

      // 0x01 even then odd parity
      wr_byte(8'h01, 2'b00);
      cap(12, 0);
      for (int i = 0; i < 11; i++) chk($sformatf("01e bit%0d", i), 32'(cb[i]), 32'(e_01e[i]));
      chk("01e int", 32'(ci[11]), 32'd1);
      clr();
      wr_byte(8'h01, 2'b01);
      cap(12, 0);
      for (int i = 0; i < 11; i++) chk($sformatf("01o bit%0d", i), 32'(cb[i]), 32'(e_01o[i]));
      chk("01o int", 32'(ci[11]), 32'd1);
      clr();

      // Back-to-back frames and a dropped third write
      wr_byte(8'h3C, 2'b10);
      cap(4, 0);
      wr_byte(8'hC3, 2'b10);
      chk("b2b full", 32'(bus.o_full), 32'd1);
      wr_byte(8'h77, 2'b10);
      @(negedge i_clk);
      chk("b2b ovr", 32'(bus.o_ovr), 32'd1);
      cap(17, 4);
      for (int i = 0; i < 20; i++) chk($sformatf("b2b bit%0d", i), 32'(cb[i]), 32'(e_3c[i]));
      chk("b2b int", 32'(ci[20]), 32'd1);
      clr();

      // Chip enable freeze during data bit 3
      wr_byte(8'h08, 2'b10);
      cap(5, 0);
      @(posedge i_clk); #1 bus.i_ce_n = 1'b1;
      repeat (5 * 16) @(posedge i_clk);
      chk("ce hold", 32'(o_tx_data), 32'd1);
      chk("ce busy", 32'(bus.o_busy), 32'd1);
      #1 bus.i_ce_n = 1'b0;
      cap(6, 5);
      for (int i = 0; i < 10; i++) chk($sformatf("ce bit%0d", i), 32'(cb[i]), 32'(e_08[i]));
      chk("ce int", 32'(ci[10]), 32'd1);
      clr();

      // Asynchronous reset in the parity bit
      wr_byte(8'h96, 2'b01);
      cap(3, 0);
      wr_byte(8'h55, 2'b01);
      cap(7, 3);
      chk("pre-rst full", 32'(bus.o_full), 32'd1);
      #3 i_rst_n = 1'b0;
      #1;
      chk("rst line", 32'(o_tx_data), 32'd1);
      chk("rst busy", 32'(bus.o_busy), 32'd0);
      chk("rst full", 32'(bus.o_full), 32'd0);
      @(posedge i_clk); #1 i_rst_n = 1'b1;
      wr_byte(8'h5A, 2'b10);
      cap(10, 0);
      for (int i = 0; i < 10; i++) chk($sformatf("5a bit%0d", i), 32'(cb[i]), 32'(e_5a[i]));

      // Clear coincident with the interrupt set, then one cycle later
      wait_qt(ok);
      bus.i_clear_int_n = 1'b0;
      @(negedge i_clk);
      chk("clr same cycle", 32'(bus.o_tx_int), 32'd1);
      @(negedge i_clk);
      chk("clr next cycle", 32'(bus.o_tx_int), 32'd0);
      bus.i_clear_int_n = 1'b1;

      // Random traffic, model checked every cycle
      for (int c = 0; c < 6000; c++) begin
         @(posedge i_clk); #1;
         if (c % 500 == 0) tick_div = 2 + int'($urandom_range(0, 6));
         bus.i_wr_n        = ($urandom_range(0, 3) != 0);
         bus.i_data        = 8'($urandom);
         bus.i_verify_mode = 2'($urandom);
         bus.i_ce_n        = ($urandom_range(0, 15) == 0);
         bus.i_clear_int_n = ($urandom_range(0, 9) != 0);
         if ($urandom_range(0, 1499) == 0) begin
            #2 i_rst_n = 1'b0;
            #3 i_rst_n = 1'b1;
         end
      end
      @(posedge i_clk); #1;
      bus.i_wr_n = 1'b1;
      repeat (3) @(negedge i_clk);
      chk_en = 0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
      $finish;
   end
endmodule
